// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: definitions shared by the memory loader and the CPU/memory
// bus mux that selects between the loader and the CPU.
//   state_t         loader FSM state encoding (also exported for debug)
//   MEM_AW          default memory word-address width (AWIDTH-1)
//   sum16()         16-bit modular add used by the checksum accumulators
package mem_loader_pkg;

  localparam int AWIDTH_DEFAULT = 16;
  localparam int DWIDTH_DEFAULT = 16;
  localparam int MEM_AW         = AWIDTH_DEFAULT - 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_WR   = 3'd3,
    ST_RQ   = 3'd4,
    ST_RW   = 3'd5,
    ST_CK   = 3'd6,
    ST_DONE = 3'd7
  } state_t;

  // Checksums are plain 16-bit sums; the carry out is deliberately dropped.
  function automatic logic [15:0] sum16(input logic [15:0] a, input logic [15:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/mem_loader_sum.sv
// mem_loader_sum: 16-bit modular accumulator.
//   clk, rst  clock, asynchronous active-high reset (sum -> 0)
//   clr       synchronous clear; wins over add
//   add       add din into the running sum this cycle
//   din       value to accumulate
//   sum       current accumulated value (carry discarded)
module mem_loader_sum
  import mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        add,
  input  logic [15:0] din,
  output logic [15:0] sum
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum16(sum, din);
    end
  end

endmodule

// File: rtl/mem_loader.sv
// mem_loader: bus initiator that loads a host byte stream into memory and
// verifies it by reading the range back and comparing 16-bit checksums.
//   clk, rst       clock, asynchronous active-high reset
//   start          begin a load (only honoured in IDLE)
//   base_addr      first word address, captured on start
//   word_count     number of words to load, captured on start
//   in_valid/in_data/in_ready   host byte stream
//   mem_re/mem_we/memaddr/wmemdata/rmemdata   memory bus (read data one
//                  cycle after mem_re)
//   busy           high whenever the FSM is not in IDLE
//   done           one-cycle pulse at the end of a load
//   err            sticky failure flag, rises with done, cleared by start
//   cpu_rst_hold   keeps the CPU in reset until a load verifies cleanly
//   state_dbg      current FSM state
//
// Stream handshake: a byte transfers on a rising edge where in_valid and
// in_ready are both high; in_valid may be held or dropped freely, and
// in_ready depends only on the FSM state (high in HI and LO).
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-2:0] base_addr,
  input  logic [AWIDTH-1:0] word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_re,
  output logic              mem_we,
  output logic [AWIDTH-2:0] memaddr,
  output logic [DWIDTH-1:0] wmemdata,
  input  logic [DWIDTH-1:0] rmemdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst_hold,
  output state_t            state_dbg
);

  localparam int MAW = AWIDTH - 1;
  // Largest legal word_count: the whole address space, 2^(AWIDTH-1) words.
  localparam logic [AWIDTH-1:0] MAX_COUNT = {1'b1, {(AWIDTH-1){1'b0}}};

  if (DWIDTH != 16) begin : g_dwidth_check
    $error("mem_loader: only DWIDTH=16 is supported");
  end

  state_t            state;
  state_t            state_next;
  logic [AWIDTH-1:0] index_q;
  logic [AWIDTH-1:0] index_next;
  logic [AWIDTH-1:0] index_inc;
  logic [MAW-1:0]    base_q;
  logic [AWIDTH-1:0] count_q;
  logic [7:0]        hi_q;
  logic              err_pend;
  logic              start_acc;
  logic              byte_hs;
  logic              too_big;
  logic [15:0]       wsum;
  logic [15:0]       rsum;

  assign in_ready  = (state == ST_HI) || (state == ST_LO);
  assign byte_hs   = in_valid && in_ready;
  assign too_big   = word_count > MAX_COUNT;
  assign index_inc = index_q + AWIDTH'(1);
  assign state_dbg = state;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and next word index
  always_comb begin
    state_next = state;
    index_next = index_q;
    start_acc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_acc  = 1'b1;
          index_next = '0;
          if (word_count == '0 || too_big) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_HI;
          end
        end
      end
      ST_HI: begin
        if (byte_hs) state_next = ST_LO;
      end
      ST_LO: begin
        if (byte_hs) state_next = ST_WR;
      end
      ST_WR: begin
        // The last write rewinds the index so verification starts at base.
        if (index_inc == count_q) begin
          index_next = '0;
          state_next = ST_RQ;
        end else begin
          index_next = index_inc;
          state_next = ST_HI;
        end
      end
      ST_RQ: begin
        state_next = ST_RW;
      end
      ST_RW: begin
        index_next = index_inc;
        state_next = (index_inc == count_q) ? ST_CK : ST_RQ;
      end
      ST_CK: begin
        state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Registered outputs and datapath. Bus strobes are registered from the
  // next state so they are high exactly while the FSM sits in WR / RQ; the
  // address uses the next index so it is already correct in that cycle.
  // done, err and cpu_rst_hold are registered from DONE, so they change
  // together in the cycle after DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q      <= '0;
      base_q       <= '0;
      count_q      <= '0;
      hi_q         <= '0;
      mem_re       <= 1'b0;
      mem_we       <= 1'b0;
      memaddr      <= '0;
      wmemdata     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_pend     <= 1'b0;
      cpu_rst_hold <= 1'b1;
    end else begin
      index_q <= index_next;
      mem_we  <= (state_next == ST_WR);
      mem_re  <= (state_next == ST_RQ);
      busy    <= (state_next != ST_IDLE);
      done    <= (state == ST_DONE);

      if (state_next == ST_WR || state_next == ST_RQ) begin
        memaddr <= base_q + index_next[MAW-1:0];
      end

      if (start_acc) begin
        base_q   <= base_addr;
        count_q  <= word_count;
        err      <= 1'b0;
        err_pend <= too_big;
      end

      if (state == ST_HI && byte_hs) begin
        hi_q <= in_data;
      end

      if (state == ST_LO && byte_hs) begin
        wmemdata <= {hi_q, in_data};
      end

      if (state == ST_CK) begin
        err_pend <= (rsum != wsum);
      end

      if (state == ST_DONE) begin
        err          <= err_pend;
        cpu_rst_hold <= err_pend;
      end
    end
  end

  mem_loader_sum u_wsum (
    .clk (clk),
    .rst (rst),
    .clr (start_acc),
    .add (state == ST_WR),
    .din (wmemdata),
    .sum (wsum)
  );

  mem_loader_sum u_rsum (
    .clk (clk),
    .rst (rst),
    .clr (start_acc),
    .add (state == ST_RW),
    .din (rmemdata),
    .sum (rsum)
  );

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;
  import mem_loader_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [14:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        mem_re;
  logic        mem_we;
  logic [14:0] memaddr;
  logic [15:0] wmemdata;
  logic [15:0] rmemdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_rst_hold;
  state_t      state_dbg;

  always #5 clk = ~clk;

  mem_loader #(.AWIDTH(16), .DWIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .word_count   (word_count),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .memaddr      (memaddr),
    .wmemdata     (wmemdata),
    .rmemdata     (rmemdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .cpu_rst_hold (cpu_rst_hold),
    .state_dbg    (state_dbg)
  );

  // ---------------- memory responder ----------------
  logic [15:0] mem [0:32767];
  int          corrupt_addr = -1;

  always @(posedge clk) begin
    if (mem_we) mem[memaddr] <= (int'(memaddr) == corrupt_addr) ? 16'h0000 : wmemdata;
    if (mem_re) rmemdata <= mem[memaddr];
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  int          done_count = 0;
  logic [30:0] exp_wr_q[$];   // {addr, data}
  logic [14:0] exp_rd_q[$];   // addr
  logic [1:0]  exp_done_q[$]; // {err, cpu_rst_hold}
  logic [7:0]  tx_bytes[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: compares every bus strobe and done pulse against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we && mem_re) check("bus_exclusive", 32'd1, 32'd0);
      if (mem_we) begin
        if (exp_wr_q.size() == 0) check("unexpected_write", {17'b0, memaddr}, 32'hFFFF_FFFF);
        else begin
          logic [30:0] e;
          e = exp_wr_q.pop_front();
          check("write_addr", {17'b0, memaddr}, {17'b0, e[30:16]});
          check("write_data", {16'b0, wmemdata}, {16'b0, e[15:0]});
        end
      end
      if (mem_re) begin
        if (exp_rd_q.size() == 0) check("unexpected_read", {17'b0, memaddr}, 32'hFFFF_FFFF);
        else check("read_addr", {17'b0, memaddr}, {17'b0, exp_rd_q.pop_front()});
      end
      if (done) begin
        done_count++;
        if (exp_done_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          logic [1:0] d;
          d = exp_done_q.pop_front();
          check("done_err", {31'b0, err}, {31'b0, d[1]});
          check("done_cpu_rst_hold", {31'b0, cpu_rst_hold}, {31'b0, d[0]});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [14:0] b, input logic [15:0] c);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; word_count = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int stall);
    int t;
    in_valid = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("byte_accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int t;
    t = 0;
    while (done_count == prev && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) check("done_timeout", 32'd1, 32'd0);
  endtask

  // Reference model: word i is the big-endian pair of bytes 2i,2i+1 and
  // lands at (base+i) mod 2^15; the verify reads give back the same words
  // except at the corrupted address, and err is whether the sums differ.
  task automatic run_load(input logic [14:0] base, input int n, input int stall_min,
                          input int stall_max, input int corrupt, input bit mid_start,
                          input bit abort_in_rq);
    logic [15:0] w;
    logic [15:0] ws;
    logic [15:0] rs;
    logic [14:0] a;
    logic        e;
    int          prev;
    int          t;
    while (tx_bytes.size() < 2 * n) tx_bytes.push_back(8'($urandom_range(0, 255)));
    ws = '0;
    rs = '0;
    for (int i = 0; i < n; i++) begin
      w = {tx_bytes[2*i], tx_bytes[2*i+1]};
      a = base + 15'(i);
      exp_wr_q.push_back({a, w});
      exp_rd_q.push_back(a);
      ws = ws + w;
      rs = rs + ((int'(a) == corrupt) ? 16'h0000 : w);
    end
    e = (ws != rs);
    exp_done_q.push_back({e, e});
    corrupt_addr = corrupt;
    prev = done_count;
    do_start(base, 16'(n));
    @(negedge clk);
    check("busy_after_start", {31'b0, busy}, 32'd1);
    check("in_ready_after_start", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 2 * n; i++) begin
      send_byte(tx_bytes[i], $urandom_range(stall_max, stall_min));
      if (mid_start && i == 1) begin
        start = 1'b1; base_addr = 15'h0055; word_count = 16'd1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    tx_bytes.delete();
    if (abort_in_rq) begin
      t = 0;
      @(negedge clk);
      while (state_dbg != ST_RQ && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) check("reach_rq_timeout", 32'd1, 32'd0);
      check("rq_mem_re_high", {31'b0, mem_re}, 32'd1);
      #1 rst = 1'b1;
      #1;
      check("rst_mid_mem_re", {31'b0, mem_re}, 32'd0);
      check("rst_mid_mem_we", {31'b0, mem_we}, 32'd0);
      check("rst_mid_state", 32'(state_dbg), 32'(ST_IDLE));
      check("rst_mid_busy", {31'b0, busy}, 32'd0);
      check("rst_mid_cpu_rst_hold", {31'b0, cpu_rst_hold}, 32'd1);
      exp_wr_q.delete();
      exp_rd_q.delete();
      exp_done_q.delete();
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      wait_done(prev);
    end
    corrupt_addr = -1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int prev;
    int cycles;
    logic [14:0] rb;
    int rn;
    int rc;

    for (int i = 0; i < 32768; i++) mem[i] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_cpu_rst_hold", {31'b0, cpu_rst_hold}, 32'd1);
    check("rst_mem_re", {31'b0, mem_re}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_memaddr", {17'b0, memaddr}, 32'd0);
    check("rst_wmemdata", {16'b0, wmemdata}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);

    // corrupted verify: err set, CPU stays held
    tx_bytes = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
    run_load(15'h0010, 3, 0, 0, 32'h11, 1'b0, 1'b0);
    check("corrupt_err_sticky", {31'b0, err}, 32'd1);
    check("corrupt_hold", {31'b0, cpu_rst_hold}, 32'd1);

    // basic load 12 34 AB CD 00 01 at 0x10
    tx_bytes = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
    run_load(15'h0010, 3, 0, 0, -1, 1'b0, 1'b0);
    check("mem_0x10", {16'b0, mem[15'h10]}, 32'h1234);
    check("mem_0x11", {16'b0, mem[15'h11]}, 32'hABCD);
    check("mem_0x12", {16'b0, mem[15'h12]}, 32'h0001);
    check("basic_hold", {31'b0, cpu_rst_hold}, 32'd0);

    // zero-length load: done two cycles after start, no bus activity
    exp_done_q.push_back(2'b00);
    do_start(15'h0123, 16'd0);
    cycles = 1;
    @(negedge clk);
    while (!done && cycles < 10) begin
      @(negedge clk);
      cycles++;
    end
    check("zero_count_done_latency", 32'(cycles), 32'd2);
    @(negedge clk);

    // address wrap 0x7FFF -> 0x0000
    tx_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load(15'h7FFF, 2, 0, 0, -1, 1'b0, 1'b0);
    check("wrap_mem_7fff", {16'b0, mem[15'h7FFF]}, 32'hDEAD);
    check("wrap_mem_0000", {16'b0, mem[15'h0000]}, 32'hBEEF);

    // 20-cycle stalls between bytes plus an ignored start mid-load
    tx_bytes = '{8'h5A, 8'hA5, 8'h01, 8'h02, 8'hFF, 8'hFE};
    run_load(15'h0200, 3, 20, 20, -1, 1'b1, 1'b0);
    check("stall_mem_0200", {16'b0, mem[15'h0200]}, 32'h5AA5);
    check("stall_mem_0201", {16'b0, mem[15'h0201]}, 32'h0102);
    check("stall_mem_0202", {16'b0, mem[15'h0202]}, 32'hFFFE);
    check("stall_mem_0055_untouched", {16'b0, mem[15'h0055]}, 32'h0000);

    // randomized loads, some with a corrupted word
    for (int k = 0; k < 8; k++) begin
      rb = 15'($urandom_range(0, 32767));
      rn = $urandom_range(1, 8);
      rc = ($urandom_range(0, 3) == 0) ? int'(15'(rb + 15'($urandom_range(0, rn - 1)))) : -1;
      run_load(rb, rn, 0, 3, rc, 1'b0, 1'b0);
    end

    // passing load, then an oversize count: immediate failure, hold re-armed
    run_load(15'h0300, 2, 0, 1, -1, 1'b0, 1'b0);
    exp_done_q.push_back(2'b11);
    prev = done_count;
    do_start(15'h0000, 16'h8001);
    wait_done(prev);
    @(negedge clk);
    check("too_big_err_sticky", {31'b0, err}, 32'd1);
    check("too_big_hold", {31'b0, cpu_rst_hold}, 32'd1);

    // passing load clears err and hold
    run_load(15'h0400, 1, 0, 0, -1, 1'b0, 1'b0);
    check("recover_err", {31'b0, err}, 32'd0);
    check("recover_hold", {31'b0, cpu_rst_hold}, 32'd0);

    // reset asserted during RQ
    run_load(15'h0500, 2, 0, 0, -1, 1'b0, 1'b1);
    @(negedge clk);
    check("post_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("post_rst_hold", {31'b0, cpu_rst_hold}, 32'd1);

    repeat (3) @(negedge clk);
    check("exp_wr_left", 32'(exp_wr_q.size()), 32'd0);
    check("exp_rd_left", 32'(exp_rd_q.size()), 32'd0);
    check("exp_done_left", 32'(exp_done_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
